// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the 5-stage MIPS pipeline.
// Keeps a shadow copy of EX/MEM/WB register tags and derives mux selects, stalls and flushes.
module fwd_hazard_ctrl #(
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] rs_d,
    input  logic [REGW-1:0] rt_d,
    input  logic [REGW-1:0] writereg_d,
    input  logic            regwrite_d,
    input  logic            memtoreg_d,
    input  logic            branch_d,
    input  logic            div_busy,
    output logic [1:0]      forwardae,
    output logic [1:0]      forwardbe,
    output logic            forwardad,
    output logic            forwardbd,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            flush_e
);

    typedef struct packed {
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] wr;
        logic            regwrite;
        logic            memtoreg;
    } slot_t;

    slot_t e_q, m_q, w_q;
    slot_t e_d, m_d, w_d;
    slot_t id_slot;

    logic lwstall;
    logic branchstall;
    logic e_hits_id;
    logic m_hits_id;

    assign id_slot = '{rs: rs_d, rt: rt_d, wr: writereg_d,
                       regwrite: regwrite_d, memtoreg: memtoreg_d};

    always_comb begin
        forwardae = 2'b00;
        if (e_q.rs != '0 && e_q.rs == m_q.wr && m_q.regwrite)
            forwardae = 2'b10;
        else if (e_q.rs != '0 && e_q.rs == w_q.wr && w_q.regwrite)
            forwardae = 2'b01;

        forwardbe = 2'b00;
        if (e_q.rt != '0 && e_q.rt == m_q.wr && m_q.regwrite)
            forwardbe = 2'b10;
        else if (e_q.rt != '0 && e_q.rt == w_q.wr && w_q.regwrite)
            forwardbe = 2'b01;
    end

    assign forwardad = (rs_d != '0) && (rs_d == m_q.wr) && m_q.regwrite;
    assign forwardbd = (rt_d != '0) && (rt_d == m_q.wr) && m_q.regwrite;

    assign e_hits_id = (e_q.wr != '0) && ((e_q.wr == rs_d) || (e_q.wr == rt_d));
    assign m_hits_id = (m_q.wr != '0) && ((m_q.wr == rs_d) || (m_q.wr == rt_d));

    assign lwstall     = e_q.memtoreg && e_q.regwrite && e_hits_id;
    assign branchstall = branch_d && ((e_q.regwrite && e_hits_id) ||
                                      (m_q.memtoreg && m_hits_id));

    assign stall_f = lwstall || branchstall || div_busy;
    assign stall_d = stall_f;
    assign stall_e = div_busy;
    // A divide holds EX in place, so the bubble waits until div_busy drops.
    assign flush_e = (lwstall || branchstall) && !div_busy;

    always_comb begin
        e_d = id_slot;
        m_d = e_q;
        w_d = m_q;
        if (stall_e) begin
            e_d = e_q;
            m_d = '0;
        end else if (flush_e) begin
            e_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench for fwd_hazard_ctrl: one record per cycle of ID inputs and
// the outputs expected from the shadow pipeline contents during that cycle.
module tb_fwd_hazard_ctrl;

    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [REGW-1:0] rs_d, rt_d, writereg_d;
    logic            regwrite_d, memtoreg_d, branch_d, div_busy;
    logic [1:0]      forwardae, forwardbe;
    logic            forwardad, forwardbd;
    logic            stall_f, stall_d, stall_e, flush_e;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REGW(REGW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .writereg_d (writereg_d),
        .regwrite_d (regwrite_d),
        .memtoreg_d (memtoreg_d),
        .branch_d   (branch_d),
        .div_busy   (div_busy),
        .forwardae  (forwardae),
        .forwardbe  (forwardbe),
        .forwardad  (forwardad),
        .forwardbd  (forwardbd),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .stall_e    (stall_e),
        .flush_e    (flush_e)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs, rt, wr;
        logic       rw, mr, br, div;
        logic [9:0] exp;   // {fae, fbe, fad, fbd, stall_f, stall_d, stall_e, flush_e}
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input string n, input logic r, input int rs, input int rt,
                       input int wr, input logic rw, input logic mr, input logic br,
                       input logic dv, input logic [1:0] fa, input logic [1:0] fb,
                       input logic fad, input logic fbd, input logic st,
                       input logic se, input logic fe);
        vec_t v;
        v.name = n; v.rst = r;
        v.rs = 5'(rs); v.rt = 5'(rt); v.wr = 5'(wr);
        v.rw = rw; v.mr = mr; v.br = br; v.div = dv;
        v.exp = {fa, fb, fad, fbd, st, st, se, fe};
        vecs.push_back(v);
    endtask

    function automatic logic [9:0] actual();
        return {forwardae, forwardbe, forwardad, forwardbd,
                stall_f, stall_d, stall_e, flush_e};
    endfunction

    task automatic check(input string n, input logic [9:0] exp);
        n_vec++;
        if (actual() !== exp) begin
            n_fail++;
            $display("FAIL %s: got fae/fbe/fad/fbd/sf/sd/se/fe=%b expected %b", n, actual(), exp);
        end
    endtask

    initial begin
        //  name            rst rs rt wr rw mr br dv   fae    fbe   fad fbd st se fe
        add("exex_add3",     0, 1, 2, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("exex_sub_id",   0, 3, 7, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("exex_fa_mem",   0, 3, 0, 9, 1, 0, 0, 0, 2'b10, 2'b00, 1, 0, 0, 0, 0);
        add("exex_fa_wb",    0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        add("rt_add3",       0, 1, 2, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("rt_sub_id",     0, 7, 3, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("rt_fb_mem",     0, 0, 3, 9, 1, 0, 0, 0, 2'b00, 2'b10, 0, 1, 0, 0, 0);
        add("rt_fb_wb",      0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        add("prio_w1",       0, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("prio_w2",       0, 2, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("prio_rd_id",    0, 5, 0,10, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        add("prio_mem_wins", 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        add("r0_writer",     0, 1, 2, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("r0_beq",        0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("r0_no_fwd",     0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("lu_lw4",        0, 1, 4, 4, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("lu_stall",      0, 2, 4, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        add("lu_no_stall",   0, 2, 4, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0);
        add("lu_fb_wb",      0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        add("br_alu6",       0, 1, 2, 6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("br_alu_stall",  0, 6, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        add("br_alu_fad",    0, 6, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        add("br_lw6",        0, 1, 6, 6, 1, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        add("br_lw_stall1",  0, 6, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        add("br_lw_stall2",  0, 6, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1, 0, 1);
        add("br_lw_go",      0, 6, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("div_w1",        0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("div_lw4",       0, 1, 4, 4, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("div_c1",        0, 4, 2, 7, 1, 0, 0, 1, 2'b10, 2'b00, 0, 0, 1, 1, 0);
        add("div_c2",        0, 4, 2, 7, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0, 1, 1, 0);
        add("div_c3",        0, 4, 2, 7, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1, 0);
        add("div_lw_flush",  0, 4, 2, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        add("div_resume",    0, 4, 2, 7, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        add("div_fa_wb",     0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        add("nrw_issue",     0, 1, 2, 9, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("nrw_br",        0, 9, 9, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("nrw_mem",       0, 9, 9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("nrw_wb",        0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("lw0_issue",     0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("lw0_no_stall",  0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("rst_lw4",       0, 1, 4, 4, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add("rst_mid_stall", 1, 4, 4, 7, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1, 0);
        add("rst_cleared",   0, 4, 4, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rs_d       = 5'($urandom);
            rt_d       = 5'($urandom);
            writereg_d = 5'($urandom);
            regwrite_d = 1'($urandom);
            memtoreg_d = 1'($urandom);
            branch_d   = 1'($urandom);
            div_busy   = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        {rs_d, rt_d, writereg_d} = '0;
        {regwrite_d, memtoreg_d, branch_d, div_busy} = '0;
        #1 check("reset_state", '0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            rs_d       = vecs[i].rs;
            rt_d       = vecs[i].rt;
            writereg_d = vecs[i].wr;
            regwrite_d = vecs[i].rw;
            memtoreg_d = vecs[i].mr;
            branch_d   = vecs[i].br;
            div_busy   = vecs[i].div;
            #1 check(vecs[i].name, vecs[i].exp);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
